// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin front end for an external shared left-shift stage.
// Each job is split into passes of at most 3 bit positions. The stage sees
// the running operand plus a one-hot shift select, and its result is folded
// back into the accumulator until the whole amount has been applied.
module shift_arb_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  input  logic [2:0] req0_amt,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  input  logic [2:0] req1_amt,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic [3:0] sh_din,
  output logic [3:0] sh_onehot,
  input  logic [3:0] sh_dout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       last_grant;
  logic [3:0] acc;
  logic [2:0] rem;
  logic       id;
  // Set for the single IDLE cycle that follows a completed response, so the
  // response handshake and the next acceptance never share a cycle.
  logic       hold_off;
  logic       grant_any;
  logic       grant_id;
  logic [1:0] step;

  assign busy = (state != IDLE);

  // Arbitration, next-state selection and all combinational outputs.
  always_comb begin
    next_state = state;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = 4'b0000;
    rsp_id     = 1'b0;
    sh_din     = 4'b0000;
    sh_onehot  = 4'b0000;
    step       = (rem > 3'd3) ? 2'd3 : rem[1:0];
    case (state)
      IDLE: begin
        if (rst_n && !hold_off) begin
          if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
          end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
          end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
          end
        end
        req0_ready = grant_any & ~grant_id;
        req1_ready = grant_any & grant_id;
        if (grant_any) next_state = EXEC;
      end
      EXEC: begin
        sh_din    = acc;
        sh_onehot = 4'b0001 << step;
        if (rem <= 3'd3) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = acc;
        rsp_id    = id;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Job capture on acceptance, per-pass accumulator update, hold-off flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      acc        <= 4'b0000;
      rem        <= 3'd0;
      id         <= 1'b0;
      hold_off   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hold_off <= 1'b0;
          if (grant_any) begin
            acc        <= grant_id ? req1_data : req0_data;
            rem        <= grant_id ? req1_amt : req0_amt;
            id         <= grant_id;
            last_grant <= grant_id;
          end
        end
        EXEC: begin
          acc <= sh_dout;
          rem <= rem - {1'b0, step};
        end
        RESP: begin
          if (rsp_ready) hold_off <= 1'b1;
        end
        default: hold_off <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has a shift job pending.
REQ-005 req0_data / req1_data  input  4  operand from requester N.
REQ-006 req0_amt / req1_amt  input  3  binary left-shift amount, 0..7.
REQ-007 req0_ready / req1_ready  output  1  job from requester N is accepted this cycle.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_data  output  4  shifted result, truncated to 4 bits.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_ready  input  1  consumer takes the result.
REQ-012 sh_din  output  4  operand driven to the external shared shift stage.
REQ-013 sh_onehot  output  4  one-hot shift select to the stage; bit k selects a shift of k.
REQ-014 sh_dout  input  4  stage result, dout[k] = OR of din[i]&onehot[j] over all i+j=k.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-017 In IDLE, when at least one valid is high, the block SHALL grant one requester by round-robin: the requester not recorded in last_grant wins a tie, and a lone requester always wins.
REQ-018 reqN_ready SHALL be high only in IDLE for the granted N, combinationally from the valids; both readys SHALL never be high in the same cycle.
REQ-019 A transfer SHALL occur when valid&ready; it loads acc=data, rem=amt and id=N, sets last_grant=N, and moves the FSM to EXEC.
REQ-020 Requesters SHALL hold valid, data and amt stable until ready; the block does not check this.
REQ-021 In EXEC, step=min(rem,3), sh_din=acc, and sh_onehot=1<<step.
REQ-022 Each EXEC cycle SHALL set acc<=sh_dout and rem<=rem-step.
REQ-023 The EXEC cycle in which rem<=3 SHALL be the last one, moving the FSM to RESP.
REQ-024 Pass count SHALL be: amt 0..3 gives 1 pass, 4..6 gives 2 passes, 7 gives 3 passes.
  - amt=0 still performs one pass with sh_onehot=0001.
REQ-025 Outside EXEC, sh_din SHALL be 0000 and sh_onehot SHALL be 0000.
REQ-026 In RESP, rsp_valid=1 and rsp_data=acc, rsp_id=id; these SHALL hold stable until rsp_ready is high.
REQ-027 rsp_valid&rsp_ready SHALL return the FSM to IDLE.
  - No new request is accepted in that same cycle; the earliest next acceptance is the following cycle.
REQ-028 Latency: with acceptance in cycle T and P passes, rsp_valid SHALL first be high in cycle T+1+P.
REQ-029 While the FSM is in EXEC or RESP, both readys SHALL be low regardless of the valids.
REQ-030 Arithmetic SHALL be a logical left shift: zeros are shifted in, and bits above bit 3 are discarded on every pass.

Reset
REQ-031 While rst_n=0, the block SHALL force the following regardless of clk:
  - state=IDLE, last_grant=1, acc=0000, rem=0, id=0;
  - rsp_valid=0, rsp_data=0000, rsp_id=0, busy=0;
  - sh_din=0000, sh_onehot=0000;
  - both readys low.
REQ-032 Reset asserted mid-job SHALL discard the in-flight job and any pending response without emitting a result.
  - After release, the first grant goes to req0 if req0 is valid.

Verification
REQ-033 After reset, req0 sends data=0011, amt=1, with rsp_ready high.
  - req0_ready is high in the accept cycle T.
  - In T+1, sh_onehot=0010.
  - In T+2, rsp_valid=1, rsp_data=0110, rsp_id=0.
REQ-034 req1 sends data=1111, amt=4.
  - EXEC runs two cycles, with sh_onehot=1000 then 0010.
  - rsp_data=0000 and rsp_id=1 appear at T+3.
REQ-035 req0 and req1 both hold valid continuously, with rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - Each accept is 4 cycles apart for amt=1.
REQ-036 Hold rsp_ready=0 for 5 cycles during RESP.
  - rsp_valid, rsp_data and rsp_id stay constant.
  - Both readys stay low.
  - The FSM returns to IDLE the cycle after rsp_ready rises.
REQ-037 Assert rst_n=0 during EXEC of a req1 job, then release with both requesters valid.
  - All outputs are zero immediately on assertion.
  - No response is issued for the aborted job.
  - req0 is granted first after release.
REQ-038 req0 sends data=1010, amt=0.
  - There is one EXEC cycle with sh_onehot=0001.
  - rsp_data=1010 appears at T+2.
